ss_decoder_5bit: RTL and testbench



---
 rtl/ss_decoder_5bit.sv | 124 ++++++++++++
 tb/tb_ss_decoder_5bit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_decoder_5bit.sv
// ss_decoder_5bit
// Receive end of the stochastic-symbol path: accumulates one frame of 2^FRAME_LOG2 symbols
// and returns the rounded binary estimate of the frame mean on a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a frame (honoured in IDLE, or in HOLD together with out_ready)
//   ss_valid   ss_in carries a symbol this cycle
//   ss_in      symbol value, unsigned
//   busy       high while a frame is being accumulated
//   out_valid  z_output holds a completed frame result
//   out_ready  consumer accepts z_output
//   z_output   decoded binary value (kept until the next frame completes)
module ss_decoder_5bit #(
    parameter int unsigned SS_WIDTH   = 5,
    parameter int unsigned OUT_WIDTH  = 12,
    parameter int unsigned FRAME_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ss_valid,
    input  logic [SS_WIDTH-1:0]  ss_in,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] z_output
);

    // Sum of a full frame of maximum symbols fits exactly, so no overflow handling is needed.
    localparam int unsigned ACC_WIDTH = SS_WIDTH + FRAME_LOG2;
    localparam int SHIFT_S = int'(FRAME_LOG2) - (int'(OUT_WIDTH) - int'(SS_WIDTH));

    if (SHIFT_S < 0) begin : g_bad_params
        $error("ss_decoder_5bit: FRAME_LOG2 must be >= OUT_WIDTH - SS_WIDTH");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    state_e                 state_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [FRAME_LOG2-1:0]  cnt_q;
    logic                   busy_q;
    logic                   out_valid_q;
    logic [OUT_WIDTH-1:0]   z_q;

    logic [ACC_WIDTH-1:0]   final_sum;
    logic [OUT_WIDTH-1:0]   result;

    assign final_sum = acc_q + ACC_WIDTH'(ss_in);

    if (SHIFT_S > 0) begin : g_round
        localparam int unsigned SHIFT = unsigned'(SHIFT_S);
        logic [ACC_WIDTH-1:0] sum_rnd;
        // Round half up; the add cannot carry out since the frame sum is bounded below 2^ACC_WIDTH
        // by at least 2^FRAME_LOG2.
        assign sum_rnd = final_sum + (ACC_WIDTH'(1) << (SHIFT - 1));
        assign result  = OUT_WIDTH'(sum_rnd >> SHIFT);
    end else begin : g_no_round
        assign result = OUT_WIDTH'(final_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (ss_valid) begin
                        // Terminal beat: counter all ones means this is symbol 2^FRAME_LOG2.
                        if (&cnt_q) begin
                            z_q         <= result;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= StHold;
                        end else begin
                            acc_q <= final_sum;
                            cnt_q <= cnt_q + FRAME_LOG2'(1);
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (start) begin
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= StAccum;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign z_output  = z_q;

endmodule

// File: tb/tb_ss_decoder_5bit.sv
// Self-checking bench for ss_decoder_5bit at default parameters.
module tb_ss_decoder_5bit;

    localparam int SS_W  = 5;
    localparam int OUT_W = 12;
    localparam int FL2   = 8;
    localparam int N     = 1 << FL2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             ss_valid;
    logic [SS_W-1:0]  ss_in;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] z_output;

    int checks = 0;
    int errors = 0;
    int syms[N];

    always #5 clk = ~clk;

    ss_decoder_5bit #(
        .SS_WIDTH  (SS_W),
        .OUT_WIDTH (OUT_W),
        .FRAME_LOG2(FL2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ss_valid (ss_valid),
        .ss_in    (ss_in),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z_output (z_output)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame mean scaled to OUT_W bits, rounded half up: round(sum * 2^(OUT_W-SS_W) / N).
    function automatic int model();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += syms[i];
        return (2 * s * (1 << (OUT_W - SS_W)) + N) / (2 * N);
    endfunction

    // Drives n accepted symbols from syms[], with random stall cycles. Counts cycles where the
    // decoder looked finished (out_valid or !busy) before the last symbol of a frame.
    task automatic feed_frame(input int n, input int stall_pct, input bit pulse_start,
                              output int early);
        int tries;
        early = 0;
        for (int i = 0; i < n; i++) begin
            tries = 0;
            while (tries < 50 && $urandom_range(99) < stall_pct) begin
                ss_valid = 1'b0;
                ss_in    = SS_W'($urandom);
                start    = pulse_start ? 1'($urandom) : 1'b0;
                step();
                tries++;
                if (out_valid || !busy) early++;
            end
            ss_valid = 1'b1;
            ss_in    = SS_W'(syms[i]);
            start    = pulse_start ? 1'($urandom) : 1'b0;
            step();
            if (i < N - 1 && (out_valid || !busy)) early++;
        end
        ss_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ss_valid = 1'b1; ss_in = 5'd31; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0; ss_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (z_output !== '0) begin errors++; $display("FAIL reset_z got %0d want 0", z_output); end
    endtask

    task automatic test_basic();
        int early;
        int exp;
        for (int i = 0; i < N; i++) syms[i] = 16;
        exp = model();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_start busy %b out_valid %b want 1 0", busy, out_valid);
        end
        feed_frame(N, 0, 1'b0, early);
        checks++;
        if (early !== 0) begin errors++; $display("FAIL basic_early got %0d want 0", early); end
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done out_valid %b busy %b want 1 0", out_valid, busy);
        end
        checks++;
        if (z_output !== 12'(exp) || exp != 2048) begin
            errors++; $display("FAIL basic_z got %0d want %0d", z_output, exp);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || z_output !== 12'(exp)) begin
            errors++;
            $display("FAIL basic_handshake out_valid %b busy %b z %0d want 0 0 %0d",
                     out_valid, busy, z_output, exp);
        end
    endtask

    task automatic test_patterns();
        int early;
        int exp;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < N; i++) begin
                case (p)
                    0: syms[i] = 0;
                    1: syms[i] = 31;
                    2: syms[i] = (i == N - 1) ? 0 : 1;
                    3: syms[i] = i % 2;
                    default: syms[i] = int'($urandom_range(31));
                endcase
            end
            exp = model();
            start = 1'b1;
            step();
            start = 1'b0;
            feed_frame(N, (p >= 4) ? 20 : 0, 1'b0, early);
            checks++;
            if (early !== 0) begin
                errors++; $display("FAIL pattern%0d_early got %0d want 0", p, early);
            end
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL pattern%0d_done out_valid %b busy %b want 1 0", p, out_valid, busy);
            end
            checks++;
            if (z_output !== 12'(exp)) begin
                errors++; $display("FAIL pattern%0d_z got %0d want %0d", p, z_output, exp);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_stall_backpressure();
        int early;
        int exp;
        for (int i = 0; i < N; i++) syms[i] = 7;
        exp = model();
        start = 1'b1;
        step();
        start = 1'b0;
        feed_frame(N, 50, 1'b0, early);
        checks++;
        if (early !== 0) begin errors++; $display("FAIL stall_early got %0d want 0", early); end
        checks++;
        if (out_valid !== 1'b1 || z_output !== 12'(exp)) begin
            errors++;
            $display("FAIL stall_z out_valid %b z %0d want 1 %0d", out_valid, z_output, exp);
        end
        for (int c = 0; c < 10; c++) begin
            out_ready = 1'b0; ss_valid = 1'b1; ss_in = 5'd31; start = 1'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b0 || z_output !== 12'(exp)) begin
                errors++;
                $display("FAIL hold_cycle%0d out_valid %b busy %b z %0d want 1 0 %0d",
                         c, out_valid, busy, z_output, exp);
            end
        end
        out_ready = 1'b1; start = 1'b0; ss_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_release out_valid %b busy %b want 0 0", out_valid, busy);
        end
        // In IDLE: symbols and out_ready must not change anything.
        ss_valid = 1'b1;
        step();
        step();
        ss_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || z_output !== 12'(exp)) begin
            errors++;
            $display("FAIL idle_ignore out_valid %b busy %b z %0d want 0 0 %0d",
                     out_valid, busy, z_output, exp);
        end
    endtask

    task automatic test_back_to_back();
        int early;
        int exp;
        int prev;
        for (int i = 0; i < N; i++) syms[i] = int'($urandom_range(31));
        prev = model();
        start = 1'b1;
        step();
        start = 1'b0;
        feed_frame(N, 0, 1'b0, early);
        checks++;
        if (out_valid !== 1'b1 || z_output !== 12'(prev)) begin
            errors++;
            $display("FAIL b2b_first out_valid %b z %0d want 1 %0d", out_valid, z_output, prev);
        end
        for (int i = 0; i < N; i++) syms[i] = 8;
        exp = model();
        start = 1'b1; out_ready = 1'b1; ss_valid = 1'b1; ss_in = 5'd31;
        step();
        start = 1'b0; out_ready = 1'b0; ss_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || z_output !== 12'(prev)) begin
            errors++;
            $display("FAIL b2b_restart busy %b out_valid %b z %0d want 1 0 %0d",
                     busy, out_valid, z_output, prev);
        end
        feed_frame(N, 25, 1'b1, early);
        checks++;
        if (early !== 0) begin errors++; $display("FAIL b2b_early got %0d want 0", early); end
        checks++;
        if (out_valid !== 1'b1 || z_output !== 12'(exp) || exp != 1024) begin
            errors++;
            $display("FAIL b2b_z out_valid %b z %0d want 1 %0d", out_valid, z_output, exp);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int early;
        int exp;
        for (int i = 0; i < N; i++) syms[i] = 31;
        start = 1'b1;
        step();
        start = 1'b0;
        feed_frame(100, 0, 1'b0, early);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || z_output !== '0) begin
            errors++;
            $display("FAIL rst_mid busy %b out_valid %b z %0d want 0 0 0",
                     busy, out_valid, z_output);
        end
        for (int i = 0; i < N; i++) syms[i] = 1;
        exp = model();
        start = 1'b1;
        step();
        start = 1'b0;
        feed_frame(N, 0, 1'b0, early);
        checks++;
        if (early !== 0 || out_valid !== 1'b1 || z_output !== 12'(exp) || exp != 128) begin
            errors++;
            $display("FAIL rst_mid_frame early %0d out_valid %b z %0d want 0 1 %0d",
                     early, out_valid, z_output, exp);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || z_output !== '0) begin
            errors++;
            $display("FAIL rst_hold out_valid %b busy %b z %0d want 0 0 0",
                     out_valid, busy, z_output);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ss_valid = 1'b0; ss_in = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_patterns();
        test_stall_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
